// File: rtl/sensor_buffer_reader.sv
// sensor_buffer_reader: consumer side of a sensor timestamp buffer.
// A request carries a target timestamp T. The block pops {data, ts} entries,
// throws away samples older than T-TOLERANCE, and answers with one of three results:
//   HIT     - the sample is inside [lo, hi]
//   MISS    - the next sample is later than hi; it stays held for a later request
//   TIMEOUT - no entry arrived within TIMEOUT_CYCLES cycles
//
// Handshakes:
//   req_valid/req_ready and out_valid/out_ready are strict valid/ready pairs.
//   A transfer happens on a rising edge where both signals are high.
//   Once out_valid is raised, it and every out_* field hold steady until that transfer.
//   req_ready is high only in IDLE, so req_valid is ignored in every other state.
//   out_ready is ignored everywhere except EMIT.
module sensor_buffer_reader #(
    parameter int          DATA_WIDTH     = 512,
    parameter int          BUFFER_DEPTH   = 16,
    parameter int          ADDR_WIDTH     = $clog2(BUFFER_DEPTH),
    parameter logic [63:0] TOLERANCE      = 64'd1000,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          DROP_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [63:0]              req_ts,
    output logic                     req_ready,
    output logic                     fifo_rd_en,
    input  logic [DATA_WIDTH+63:0]   fifo_dout,
    input  logic [ADDR_WIDTH:0]      fifo_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [63:0]              out_ts,
    output logic [1:0]               out_status,
    output logic [DROP_W-1:0]        drop_count,
    output logic [2:0]               dbg_state
);
    localparam int FW = DATA_WIDTH + 64;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_EVAL  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [63:0]           lo_q, lo_d;
    logic [63:0]           hi_q, hi_d;
    logic [FW-1:0]         hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [63:0]           out_ts_q, out_ts_d;
    logic [1:0]            out_status_q, out_status_d;
    logic [DROP_W-1:0]     drop_q, drop_d;

    logic [64:0]           hi_sum;
    logic [63:0]           hold_ts;

    assign hi_sum  = {1'b0, req_ts} + {1'b0, TOLERANCE};
    assign hold_ts = hold_q[63:0];

    // Next-state, window latch, hold register, and response fields.
    // fifo_rd_en is a single-cycle pulse while in CHECK. The buffer presents the popped
    // entry the following cycle, which is the WAIT cycle that captures it.
    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        timer_d      = timer_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ts_d     = out_ts_q;
        out_status_d = out_status_q;
        drop_d       = drop_q;
        fifo_rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    // Clamp lo at 0 and hi at all-ones so the window never wraps.
                    lo_d    = (req_ts >= TOLERANCE) ? req_ts - TOLERANCE : 64'd0;
                    hi_d    = hi_sum[64] ? {64{1'b1}} : hi_sum[63:0];
                    timer_d = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hold_valid_q) begin
                    state_d = S_EVAL;
                end else if (fifo_count != '0) begin
                    fifo_rd_en = 1'b1;
                    timer_d    = '0;
                    state_d    = S_WAIT;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = '0;
                    out_ts_d     = '0;
                    out_status_d = 2'b10;
                    state_d      = S_EMIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT: begin
                hold_d       = fifo_dout;
                hold_valid_d = 1'b1;
                state_d      = S_EVAL;
            end
            S_EVAL: begin
                if (hold_ts < lo_q) begin
                    hold_valid_d = 1'b0;
                    if (drop_q != {DROP_W{1'b1}}) drop_d = drop_q + 1'b1;
                    state_d = S_CHECK;
                end else if (hold_ts <= hi_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = hold_q[FW-1:64];
                    out_ts_d     = hold_ts;
                    out_status_d = 2'b00;
                    hold_valid_d = 1'b0;
                    state_d      = S_EMIT;
                end else begin
                    // The sample is in the future: report it and keep it for the next request.
                    out_valid_d  = 1'b1;
                    out_data_d   = '0;
                    out_ts_d     = hold_ts;
                    out_status_d = 2'b01;
                    state_d      = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers. A synchronous reset drops any sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            timer_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ts_q     <= '0;
            out_status_q <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            timer_q      <= timer_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ts_q     <= out_ts_d;
            out_status_q <= out_status_d;
            drop_q       <= drop_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ts     = out_ts_q;
    assign out_status = out_status_q;
    assign drop_count = drop_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sensor_buffer_reader.sv
// Directed testbench for sensor_buffer_reader.
// The bench models the sensor buffer as a queue. A pop presents its entry on fifo_dout
// the cycle after fifo_rd_en.
module tb_sensor_buffer_reader;
    localparam int DW = 512;
    localparam int FW = DW + 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic [63:0]    req_ts = '0;
    logic           req_ready;
    logic           fifo_rd_en;
    logic [FW-1:0]  fifo_dout = '0;
    logic [4:0]     fifo_count;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  out_data;
    logic [63:0]    out_ts;
    logic [1:0]     out_status;
    logic [15:0]    drop_count;
    logic [2:0]     dbg_state;

    logic [FW-1:0]  fifo_q[$];
    int             rd_cnt = 0;
    int             rd_bad = 0;
    int             n_pass = 0;
    int             n_fail = 0;
    int             n_total = 0;
    int             lat;
    int             rd_base;
    logic [DW-1:0]  pay;

    sensor_buffer_reader dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ts(req_ts), .req_ready(req_ready),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_count(fifo_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
        .out_status(out_status), .drop_count(drop_count), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    assign fifo_count = 5'(fifo_q.size());

    // buffer model: pop on rd_en; a pop with an empty buffer is recorded as a violation
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (fifo_q.size() == 0) rd_bad = rd_bad + 1;
            else fifo_dout <= fifo_q.pop_front();
        end
    end

    function automatic logic [DW-1:0] mk_pay(input logic [31:0] seed);
        return {16{seed}};
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] ts, input logic [DW-1:0] d);
        fifo_q.push_back({d, ts});
    endtask

    task automatic send_req(input logic [63:0] ts);
        @(negedge clk);
        check("req_ready_idle", FW'(req_ready), FW'(1));
        req_valid = 1'b1;
        req_ts    = ts;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Latency counts the accept cycle as 0.
    task automatic wait_resp(input int limit, output int l);
        l = 0;
        while (l < limit) begin
            @(negedge clk);
            l++;
            if (out_valid) break;
        end
        check("resp_arrived", FW'(out_valid), FW'(1));
    endtask

    task automatic finish_resp();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("valid_dropped", FW'(out_valid), FW'(0));
    endtask

    task automatic expect_resp(input string tag, input logic [1:0] st, input logic [63:0] ts,
                               input logic [DW-1:0] d);
        check({tag, "_status"}, FW'(out_status), FW'(st));
        check({tag, "_ts"}, FW'(out_ts), FW'(ts));
        check({tag, "_data"}, FW'(out_data), FW'(d));
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", FW'(req_ready), FW'(1));
        check("rst_out_valid", FW'(out_valid), FW'(0));
        check("rst_rd_en", FW'(fifo_rd_en), FW'(0));
        check("rst_drop", FW'(drop_count), FW'(0));
        expect_resp("rst", 2'b00, 64'd0, '0);

        // T2: a single HIT read from the buffer
        pay = mk_pay(32'hA5A5_0001);
        push(64'd5000, pay);
        rd_base = rd_cnt;
        send_req(64'd5400);
        wait_resp(20, lat);
        check("t2_latency", FW'(lat), FW'(4));
        expect_resp("t2", 2'b00, 64'd5000, pay);
        check("t2_pops", FW'(rd_cnt - rd_base), FW'(1));
        finish_resp();

        // T3: drain two stale entries, then HIT (each stale entry costs 3 cycles)
        pay = mk_pay(32'hBEEF_0003);
        push(64'd100, mk_pay(32'h1));
        push(64'd200, mk_pay(32'h2));
        push(64'd4990, pay);
        rd_base = rd_cnt;
        send_req(64'd5000);
        wait_resp(40, lat);
        check("t3_latency", FW'(lat), FW'(10));
        expect_resp("t3", 2'b00, 64'd4990, pay);
        check("t3_drop", FW'(drop_count), FW'(2));
        check("t3_pops", FW'(rd_cnt - rd_base), FW'(3));
        finish_resp();

        // T4: a future sample gives a MISS, stays held, and HITs the next request without a pop
        pay = mk_pay(32'hCAFE_0004);
        push(64'd9000, pay);
        rd_base = rd_cnt;
        send_req(64'd5000);
        wait_resp(20, lat);
        expect_resp("t4_miss", 2'b01, 64'd9000, '0);
        check("t4_miss_pops", FW'(rd_cnt - rd_base), FW'(1));
        finish_resp();
        send_req(64'd9500);
        wait_resp(20, lat);
        check("t4_hit_latency", FW'(lat), FW'(3));
        expect_resp("t4_hit", 2'b00, 64'd9000, pay);
        check("t4_hit_pops", FW'(rd_cnt - rd_base), FW'(1));
        check("t4_drop", FW'(drop_count), FW'(2));
        finish_resp();

        // T5: an empty buffer gives a TIMEOUT after 256 cycles in CHECK
        rd_base = rd_cnt;
        send_req(64'd1000);
        wait_resp(400, lat);
        check("t5_latency", FW'(lat), FW'(257));
        expect_resp("t5", 2'b10, 64'd0, '0);
        check("t5_pops", FW'(rd_cnt - rd_base), FW'(0));
        finish_resp();

        // T6: T=0 clamps lo to 0; ts==hi is a HIT; outputs hold under backpressure
        pay = mk_pay(32'hD00D_0006);
        push(64'd1000, pay);
        send_req(64'd0);
        wait_resp(20, lat);
        req_valid = 1'b1;
        req_ts    = 64'd123;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_hold_valid", FW'(out_valid), FW'(1));
            check("t6_hold_ready", FW'(req_ready), FW'(0));
            expect_resp("t6_hold", 2'b00, 64'd1000, pay);
        end
        req_valid = 1'b0;
        finish_resp();

        // ts==lo is a HIT
        pay = mk_pay(32'h0000_4000);
        push(64'd4000, pay);
        send_req(64'd5000);
        wait_resp(20, lat);
        expect_resp("lo_edge", 2'b00, 64'd4000, pay);
        finish_resp();

        // lo-1 is stale; the next entry at exactly hi is a HIT
        pay = mk_pay(32'h0000_6000);
        push(64'd3999, mk_pay(32'h3999));
        push(64'd6000, pay);
        send_req(64'd5000);
        wait_resp(20, lat);
        expect_resp("hi_edge", 2'b00, 64'd6000, pay);
        check("hi_edge_drop", FW'(drop_count), FW'(3));
        finish_resp();

        // T near 2^64-1: hi saturates instead of wrapping
        pay = mk_pay(32'hFFFF_0007);
        push({64{1'b1}}, pay);
        send_req({64{1'b1}});
        wait_resp(20, lat);
        expect_resp("hi_sat", 2'b00, {64{1'b1}}, pay);
        finish_resp();

        // T1: reset during WAIT; the next request pops a fresh entry
        push(64'd7000, mk_pay(32'h7000));
        pay = mk_pay(32'h7100);
        push(64'd7100, pay);
        send_req(64'd7000);
        lat = 0;
        while (dbg_state != 3'd2 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t1_in_wait", FW'(dbg_state), FW'(2));
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t1_req_ready", FW'(req_ready), FW'(1));
        check("t1_out_valid", FW'(out_valid), FW'(0));
        check("t1_drop", FW'(drop_count), FW'(0));
        expect_resp("t1_rst", 2'b00, 64'd0, '0);
        rd_base = rd_cnt;
        send_req(64'd7000);
        wait_resp(20, lat);
        check("t1_latency", FW'(lat), FW'(4));
        expect_resp("t1_fresh", 2'b00, 64'd7100, pay);
        check("t1_pops", FW'(rd_cnt - rd_base), FW'(1));
        finish_resp();

        check("rd_en_on_empty", FW'(rd_bad), FW'(0));

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
